// File: rtl/cnt_reader_pkg.sv
// cnt_reader_pkg: shared timer register-reader types and constants.
package cnt_reader_pkg;

    localparam int APB_DW = 32;
    localparam int WAIT_W = 4;
    localparam logic [11:0] TDR0_OFF = 12'h004;
    localparam logic [11:0] TDR1_OFF = 12'h008;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_reader_apb_wait_gen.sv
// apb_wait_gen: APB wait-state down-counter; done pulses in the cycle the count expires.
module apb_wait_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] wait_cnt;
    logic         active;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            active   <= 1'b0;
        end else if (load) begin
            wait_cnt <= value;
            active   <= value != '0;
        end else if (active) begin
            wait_cnt <= wait_cnt - 1'b1;
            active   <= wait_cnt != W'(1);
        end
    end

    // A zero load completes immediately so no wait state is inserted.
    assign done = load ? value == '0 : active && wait_cnt == W'(1);

endmodule

// File: rtl/cnt_reader.sv
// cnt_reader: APB read port for a 64-bit counter with a coherent high-word snapshot.
module cnt_reader
    import cnt_reader_pkg::*;
#(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] TDR0_ADDR   = ADDR_W'(TDR0_OFF),
    parameter logic [ADDR_W-1:0] TDR1_ADDR   = ADDR_W'(TDR1_OFF),
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [63:0]       cnt,
    input  logic              cnt_clr,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    state_t            state, state_nx;
    logic              capture, wait_done, rd0, rd1, snap_vld, cap_err;
    logic [APB_DW-1:0] shadow_hi, cap_data;

    assign capture = state == IDLE && psel && penable && !pready;
    assign rd0     = !pwrite && paddr == TDR0_ADDR;
    assign rd1     = !pwrite && paddr == TDR1_ADDR;

    apb_wait_gen #(.W(WAIT_W)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .load  (capture),
        .value (WAIT_W'(WAIT_CYCLES)),
        .done  (wait_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = capture ? (wait_done ? DONE : WAIT) : IDLE;
            WAIT:    state_nx = !psel ? IDLE : wait_done ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cap_data = rd0 ? cnt[31:0] : rd1 ? (snap_vld ? shadow_hi : cnt[63:32]) : '0;
        cap_err  = !pwrite && !rd0 && !rd1;
    end

    // Response is held from capture until the transfer ends or aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            prdata  <= '0;
            pslverr <= 1'b0;
            pready  <= 1'b0;
        end else begin
            pready <= state_nx == DONE;
            if (capture) begin
                prdata  <= cap_data;
                pslverr <= cap_err;
            end else if (state_nx == IDLE) begin
                prdata  <= '0;
                pslverr <= 1'b0;
            end
        end
    end

    // A low-word capture wins over a coincident counter clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_hi <= '0;
            snap_vld  <= 1'b0;
        end else begin
            if (capture && rd0) shadow_hi <= cnt[63:32];
            snap_vld <= capture && rd0 ? 1'b1 : (capture && rd1) || cnt_clr ? 1'b0 : snap_vld;
        end
    end

endmodule

// File: tb/tb_cnt_reader.sv
// tb_cnt_reader: randomized and directed checks of three cnt_reader builds on a shared APB bus.
module tb_cnt_reader;

    localparam logic [11:0] A0 = 12'h004;
    localparam logic [11:0] A1 = 12'h008;

    logic        clk = 1'b0, rst = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0, cnt_clr = 1'b0;
    logic [11:0] paddr = '0;
    logic [63:0] cnt = '0;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];
    int          total = 0, bad = 0;
    bit          rnd = 0;

    always #5 clk = ~clk;

    function automatic int wc(int i);
        return i == 0 ? 1 : i == 1 ? 0 : 15;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cnt_reader #(.WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 15)) u (
            .clk     (clk),
            .rst     (rst),
            .psel    (psel),
            .penable (penable),
            .pwrite  (pwrite),
            .paddr   (paddr),
            .cnt     (cnt),
            .cnt_clr (cnt_clr),
            .prdata  (prdata[g]),
            .pready  (pready[g]),
            .pslverr (pslverr[g])
        );
    end

    // Reference: a transfer starting in cycle st completes in cycle st+wc+1.
    logic        er [3], ee [3];
    logic [31:0] ed [3], md [3], sh [3];
    bit          pend [3], snap [3], me [3];
    int          st [3], rc [3];
    int          cyc = 0;
    bit          idle, t0, in_x;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            idle = !pend[i];
            t0 = 0;
            if (rst) begin
                pend[i] = 0;
                snap[i] = 0;
                sh[i] = '0;
            end else begin
                if (pend[i] && (cyc >= rc[i] || !psel)) pend[i] = 0;
                if (idle && psel && penable) begin
                    pend[i] = 1;
                    st[i] = cyc;
                    rc[i] = cyc + wc(i) + 1;
                    md[i] = '0;
                    me[i] = 0;
                    if (!pwrite && paddr == A0) begin
                        md[i] = cnt[31:0];
                        sh[i] = cnt[63:32];
                        snap[i] = 1;
                        t0 = 1;
                    end else if (!pwrite && paddr == A1) begin
                        md[i] = snap[i] ? sh[i] : cnt[63:32];
                        snap[i] = 0;
                    end else if (!pwrite) begin
                        me[i] = 1;
                    end
                end
                if (cnt_clr && !t0) snap[i] = 0;
            end
        end
        cyc++;
        for (int i = 0; i < 3; i++) begin
            in_x = pend[i] && cyc <= rc[i];
            er[i] = in_x && cyc == rc[i];
            ed[i] = in_x ? md[i] : '0;
            ee[i] = in_x && me[i];
        end
    end

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (pready[i] !== er[i] || prdata[i] !== ed[i] || pslverr[i] !== ee[i]) begin
                bad++;
                $display("FAIL cycle%0d dut%0d: pready=%b prdata=%h pslverr=%b, expected %b %h %b",
                         cyc, i, pready[i], prdata[i], pslverr[i], er[i], ed[i], ee[i]);
            end
        end
        @(posedge clk);
        #1;
        if (rnd) begin
            if ($urandom_range(3) == 0) cnt = cnt + 64'($urandom_range(5));
            if ($urandom_range(15) == 0) cnt = {$urandom, $urandom};
            cnt_clr = $urandom_range(19) == 0;
        end else begin
            cnt_clr = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic apb(input int s, input logic wr, input logic [11:0] a, input int abort_at,
                       input logic clr_cap, output logic [31:0] d, output logic e, output int lat);
        bit fin = 0;
        d = '0;
        e = 1'b0;
        lat = 0;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        cycle();
        penable = 1'b1;
        if (clr_cap) cnt_clr = 1'b1;
        for (int n = 1; n <= 40 && !fin; n++) begin
            if (pready[s]) begin
                lat = n;
                d = prdata[s];
                e = pslverr[s];
                fin = 1;
            end else if (n == abort_at) begin
                fin = 1;
            end
            cycle();
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL timeout: dut%0d gave no pready within 40 cycles", s);
        end
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        cycle();
    endtask

    logic [31:0] d;
    logic        e;
    int          lat, s, ab, r;
    logic [11:0] a;
    logic        wr;

    initial begin
        repeat (3) cycle();
        chk("reset_prdata", prdata[0], 32'h0);
        chk("reset_pready", {31'b0, pready[0]}, 32'h0);
        chk("reset_pslverr", {31'b0, pslverr[0]}, 32'h0);
        rst = 1'b0;
        cycle();

        cnt = 64'h0000_0001_FFFF_FFFF;
        apb(0, 1'b0, A0, 0, 1'b0, d, e, lat);
        chk("coherent_lo", d, 32'hFFFF_FFFF);
        cnt = 64'h0000_0002_0000_0000;
        apb(0, 1'b0, A1, 0, 1'b0, d, e, lat);
        chk("coherent_hi", d, 32'h0000_0001);

        cnt = 64'hDEAD_BEEF_0000_0010;
        apb(0, 1'b0, A1, 0, 1'b0, d, e, lat);
        chk("live_hi", d, 32'hDEAD_BEEF);
        chk("live_hi_lat", 32'(lat), 32'd3);
        chk("live_hi_err", {31'b0, e}, 32'h0);

        cnt = 64'h1111_2222_3333_4444;
        apb(0, 1'b0, A0, 0, 1'b0, d, e, lat);
        cnt = 64'h5555_6666_7777_8888;
        apb(0, 1'b0, 12'h010, 0, 1'b0, d, e, lat);
        chk("bad_addr_lat", 32'(lat), 32'd3);
        chk("bad_addr_err", {31'b0, e}, 32'h1);
        chk("bad_addr_data", d, 32'h0);
        apb(0, 1'b0, A1, 0, 1'b0, d, e, lat);
        chk("shadow_kept", d, 32'h1111_2222);

        cnt = 64'h0000_00AA_0000_0005;
        apb(0, 1'b0, A0, 0, 1'b1, d, e, lat);
        chk("clr_capture_lo", d, 32'h5);
        apb(0, 1'b0, A1, 0, 1'b0, d, e, lat);
        chk("clr_capture_hi", d, 32'h0000_00AA);
        apb(0, 1'b0, A0, 0, 1'b0, d, e, lat);
        cnt_clr = 1'b1;
        cnt = '0;
        cycle();
        apb(0, 1'b0, A1, 0, 1'b0, d, e, lat);
        chk("clr_drops_snap", d, 32'h0);

        cnt = 64'h0000_0077_0000_0001;
        apb(0, 1'b0, A0, 0, 1'b0, d, e, lat);
        psel = 1'b1;
        penable = 1'b0;
        paddr = A1;
        cycle();
        penable = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        psel = 1'b0;
        penable = 1'b0;
        chk("rst_wait_pready", {31'b0, pready[0]}, 32'h0);
        chk("rst_wait_prdata", prdata[0], 32'h0);
        cycle();
        cnt = 64'h1234_5678_0000_0000;
        apb(0, 1'b0, A1, 0, 1'b0, d, e, lat);
        chk("rst_clears_snap", d, 32'h1234_5678);

        apb(1, 1'b0, A0, 0, 1'b0, d, e, lat);
        chk("wc0_lat", 32'(lat), 32'd2);
        apb(2, 1'b0, A1, 0, 1'b0, d, e, lat);
        chk("wc15_lat", 32'(lat), 32'd17);
        apb(2, 1'b0, A1, 4, 1'b0, d, e, lat);
        chk("wc15_abort", 32'(lat), 32'd0);
        repeat (20) cycle();

        rnd = 1;
        repeat (250) begin
            r = $urandom_range(4);
            s = r < 3 ? 0 : r - 2;
            r = $urandom_range(9);
            a = r < 4 ? A0 : r < 8 ? A1 : 12'($urandom);
            wr = $urandom_range(5) == 0;
            ab = (wc(s) > 0 && $urandom_range(7) == 0) ? $urandom_range(wc(s), 1) : 0;
            apb(s, wr, a, ab, 1'b0, d, e, lat);
            if ($urandom_range(24) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            repeat ($urandom_range(2)) cycle();
        end
        rnd = 0;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
